// File: rtl/divider_pkg.sv
// Shared types and helpers for the multi-cycle restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/restoring_divider_cla_trial_sub.sv
// Combinational N-bit trial subtractor a - b = a + ~b + 1 built from 4-bit lookahead groups.
module cla_trial_sub #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N-1:0] g, p;
  logic [N:0]   c;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Carries inside a group are flattened lookahead terms off the group carry-in;
  // group carry-ins chain from one group to the next.
  always_comb begin
    logic cy, pr;
    int   base;
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      base = (i / 4) * 4;
      cy   = g[i];
      pr   = p[i];
      for (int j = 1; j < 4; j++) begin
        if (i - j >= base) begin
          cy = cy | (pr & g[i-j]);
          pr = pr & p[i-j];
        end
      end
      c[i+1] = cy | (pr & c[base]);
    end
  end

  assign diff   = p ^ c[N-1:0];
  assign borrow = ~c[N];

endmodule

// File: rtl/restoring_divider.sv
// Restoring divider, one quotient bit per clock, start/done handshake.
// DIVIDER_SIGNED_EN selects two's-complement operands (magnitude divide plus sign fix-up).
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, q_sh, dvs;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic [WIDTH:0]   rem_next, diff;
  logic             borrow;
  logic [WIDTH-1:0] q_new, r_new, fin_q, fin_r, dvd_back;
  logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in;
  logic             unused_msbs;

  assign accept = start && (state != RUN);
  assign busy   = (state == RUN);
  assign done   = (state == FINISH);

  assign rem_next = {acc, q_sh[WIDTH-1]};

  cla_trial_sub #(.N(WIDTH+1)) u_sub (
    .a      (rem_next),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Remainder is always below the divisor, so the top bit of either candidate is zero.
  assign q_new       = {q_sh[WIDTH-2:0], ~borrow};
  assign r_new       = borrow ? rem_next[WIDTH-1:0] : diff[WIDTH-1:0];
  assign unused_msbs = diff[WIDTH] ^ rem_next[WIDTH];

`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
  assign dvd_mag_in = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag_in = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign fin_q      = neg_q ? -q_new : q_new;
  assign fin_r      = neg_r ? -r_new : r_new;
  assign dvd_back   = neg_r ? -q_sh  : q_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag_in = dividend;
  assign dvs_mag_in = divisor;
  assign fin_q      = q_new;
  assign fin_r      = r_new;
  assign dvd_back   = q_sh;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (dvs == '0 || cnt == '0) state_nxt = FINISH;
      FINISH:  state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      q_sh        <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      acc         <= '0;
      q_sh        <= dvd_mag_in;
      dvs         <= dvs_mag_in;
      cnt         <= CW'(WIDTH-1);
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      if (dvs == '0) begin
        // Zero divisor: skip the loop, q_sh still holds the untouched dividend.
        quotient    <= '1;
        remainder   <= dvd_back;
        div_by_zero <= 1'b1;
      end else begin
        acc  <= r_new;
        q_sh <= q_new;
        cnt  <= cnt - 1'b1;
        if (cnt == '0) begin
          quotient  <= fin_q;
          remainder <= fin_r;
        end
      end
    end
  end

endmodule
